// File: rtl/drum_hit_pkg.sv
// rtl/drum_hit_pkg.sv - shared pad FSM states, event field widths and event type
package drum_hit_pkg;

  localparam int EVT_PAD_W   = 3;
  localparam int EVT_LEVEL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEAK,
    ST_EMIT,
    ST_LOCKOUT,
    ST_REARM
  } pad_state_t;

  typedef struct packed {
    logic [EVT_PAD_W-1:0]   pad;
    logic [EVT_LEVEL_W-1:0] velocity;
  } drum_evt_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/drum_pad_channel.sv
// rtl/drum_pad_channel.sv - one pad: synchronizer, edge detect, hit FSM, peak and counters
// DRUM_HIT_VELOCITY_EN enables the PEAK window and velocity tracking.
module drum_pad_channel
  import drum_hit_pkg::*;
#(
  parameter int LEVEL_W        = EVT_LEVEL_W,
  parameter int PEAK_WINDOW    = 500_000,
  parameter int LOCKOUT_CYCLES = 2_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ind,
  input  logic [LEVEL_W-1:0] lvl,
  input  logic               grant,
  output logic               req,
  output logic [LEVEL_W-1:0] peak,
  output logic               active
);

  localparam int CNT_W = cnt_width(PEAK_WINDOW, LOCKOUT_CYCLES);

  pad_state_t       state;
  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise   = sync2 & ~sync_prev;
  assign req    = (state == ST_EMIT);
  assign active = (state != ST_IDLE);

`ifdef DRUM_HIT_VELOCITY_EN
  logic [LEVEL_W-1:0] lvl_r;
  logic [LEVEL_W-1:0] peak_r;

  assign peak = peak_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_r  <= '0;
      peak_r <= '0;
    end else begin
      lvl_r <= lvl;
      if (state == ST_IDLE && rise) begin
        peak_r <= lvl_r;
      end else if (state == ST_PEAK && lvl_r > peak_r) begin
        peak_r <= lvl_r;
      end
    end
  end
`else
  logic unused_lvl;

  assign unused_lvl = ^lvl;
  assign peak       = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      cnt       <= '0;
      state     <= ST_IDLE;
    end else begin
      sync1     <= ind;
      sync2     <= sync1;
      sync_prev <= sync2;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cnt <= '0;
`ifdef DRUM_HIT_VELOCITY_EN
            state <= ST_PEAK;
`else
            state <= ST_EMIT;
`endif
          end
        end
`ifdef DRUM_HIT_VELOCITY_EN
        // The window includes the entry cycle, so the last count is PEAK_WINDOW-1.
        ST_PEAK: begin
          if (cnt == CNT_W'(PEAK_WINDOW - 1)) begin
            state <= ST_EMIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        ST_EMIT: begin
          if (grant) begin
            cnt   <= '0;
            state <= ST_LOCKOUT;
          end
        end
        ST_LOCKOUT: begin
          if (cnt == CNT_W'(LOCKOUT_CYCLES - 1)) begin
            state <= ST_REARM;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REARM: begin
          if (!sync2) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/drum_hit_event_queue.sv
// rtl/drum_hit_event_queue.sv - per-pad hit channels, fixed-priority arbiter and event FIFO
// DRUM_HIT_VELOCITY_EN selects peak-velocity tracking; otherwise velocity is all-ones.
module drum_hit_event_queue
  import drum_hit_pkg::*;
#(
  parameter int N_PADS         = 5,
  parameter int LEVEL_W        = EVT_LEVEL_W,
  parameter int PEAK_WINDOW    = 500_000,
  parameter int LOCKOUT_CYCLES = 2_500_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PADS-1:0]         sound_ind,
  input  logic [N_PADS*LEVEL_W-1:0] sound_lvl,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [EVT_PAD_W-1:0]      evt_pad,
  output logic [LEVEL_W-1:0]        evt_velocity,
  output logic                      overflow,
  output logic [N_PADS-1:0]         pad_active
);

  localparam int EVT_W = EVT_PAD_W + LEVEL_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_PADS-1:0]  req;
  logic [N_PADS-1:0]  grant;
  logic [LEVEL_W-1:0] peak [N_PADS];

  for (genvar g = 0; g < N_PADS; g++) begin : g_pad
    drum_pad_channel #(
      .LEVEL_W        (LEVEL_W),
      .PEAK_WINDOW    (PEAK_WINDOW),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ind    (sound_ind[g]),
      .lvl    (sound_lvl[g*LEVEL_W +: LEVEL_W]),
      .grant  (grant[g]),
      .req    (req[g]),
      .peak   (peak[g]),
      .active (pad_active[g])
    );
  end

  logic             push;
  logic [EVT_W-1:0] push_data;

  // Scan high to low so the lowest requesting pad ends up holding the grant.
  always_comb begin
    grant     = '0;
    push      = 1'b0;
    push_data = '0;
    for (int i = N_PADS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        push      = 1'b1;
        push_data = {EVT_PAD_W'(i), peak[i]};
      end
    end
  end

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             pop;
  logic             full;
  logic             accept;

  assign pop    = evt_valid & evt_ready;
  assign full   = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign accept = push & (~full | pop);

  always_comb begin
    count_next = count;
    if (accept && !pop) begin
      count_next = count + (PTR_W + 1)'(1);
    end else if (!accept && pop) begin
      count_next = count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      count     <= count_next;
      evt_valid <= (count_next != '0);
    end
  end

  assign evt_pad      = mem[rd_ptr][EVT_W-1 -: EVT_PAD_W];
  assign evt_velocity = mem[rd_ptr][LEVEL_W-1:0];

endmodule

// File: tb/tb_drum_hit_event_queue.sv
// tb/tb_drum_hit_event_queue.sv - randomized and directed bench against a timestamp-based model
// Expectations follow DRUM_HIT_VELOCITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_drum_hit_event_queue;
  import drum_hit_pkg::*;

  localparam int N     = 5;
  localparam int LW    = 8;
  localparam int PW    = 8;
  localparam int LC    = 16;
  localparam int DEPTH = 4;
`ifdef DRUM_HIT_VELOCITY_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif
  localparam int EXP_LAT = VEL_EN ? PW + 4 : 4;
  localparam int EXP_VEL = VEL_EN ? 200 : 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    sound_ind = '0;
  logic [N*LW-1:0] sound_lvl = '0;
  logic            evt_valid;
  logic            evt_ready = 1'b0;
  logic [2:0]      evt_pad;
  logic [LW-1:0]   evt_velocity;
  logic            overflow;
  logic [N-1:0]    pad_active;

  drum_hit_event_queue #(
    .N_PADS(N), .LEVEL_W(LW), .PEAK_WINDOW(PW), .LOCKOUT_CYCLES(LC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sound_ind(sound_ind), .sound_lvl(sound_lvl),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_pad(evt_pad),
    .evt_velocity(evt_velocity), .overflow(overflow), .pad_active(pad_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: each pad is a hit with timestamps (start, first push cycle, rearm cycle).
  bit        h1 [N];
  bit        h2 [N];
  bit        h3 [N];
  logic [7:0] lp [N];
  bit        busy [N];
  bit        granted [N];
  int        t_start [N];
  int        elig [N];
  int        rearm_from [N];
  logic [7:0] m_peak [N];
  drum_evt_t mq [$];
  bit        m_ovf;
  int        cyc = 0;

  int log_pad [$];
  int log_vel [$];
  int log_cyc [$];
  bit         last_valid = 1'b0;
  logic [2:0] last_pad = '0;
  logic [7:0] last_vel = '0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      h1[i] = 0; h2[i] = 0; h3[i] = 0; lp[i] = '0;
      busy[i] = 0; granted[i] = 0; m_peak[i] = '0;
    end
    mq.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    int g;
    if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
    for (int i = 0; i < N; i++) begin
      if (!busy[i]) begin
        if (h2[i] && !h3[i]) begin
          busy[i] = 1; granted[i] = 0; t_start[i] = cyc;
          m_peak[i] = VEL_EN ? lp[i] : 8'hFF;
          elig[i]   = VEL_EN ? cyc + PW + 1 : cyc + 1;
        end
      end else if (granted[i]) begin
        if (cyc >= rearm_from[i] && !h2[i]) busy[i] = 0;
      end else if (VEL_EN && cyc <= t_start[i] + PW && lp[i] > m_peak[i]) begin
        m_peak[i] = lp[i];
      end
    end
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && busy[i] && !granted[i] && cyc >= elig[i]) g = i;
    if (g >= 0) begin
      granted[g] = 1;
      rearm_from[g] = cyc + LC + 1;
      if (mq.size() < DEPTH) mq.push_back(drum_evt_t'{pad: 3'(g), velocity: m_peak[g]});
      else m_ovf = 1;
    end
    for (int i = 0; i < N; i++) begin
      h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = sound_ind[i];
      lp[i] = sound_lvl[i*LW +: LW];
    end
  endtask

  always @(posedge clk) begin
    logic [N-1:0] act;
    cyc++;
    if (rst_n && last_valid && evt_ready) begin
      log_pad.push_back(int'(last_pad));
      log_vel.push_back(int'(last_vel));
      log_cyc.push_back(cyc);
    end
    if (!rst_n) model_reset();
    else model_step();
    #1;
    for (int i = 0; i < N; i++) act[i] = busy[i];
    check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("evt_pad", 32'(evt_pad), 32'(mq[0].pad));
      check("evt_velocity", 32'(evt_velocity), 32'(mq[0].velocity));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("pad_active", 32'(pad_active), 32'(act));
    last_valid = evt_valid;
    last_pad   = evt_pad;
    last_vel   = evt_velocity;
  end

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic clear_logs();
    log_pad.delete(); log_vel.delete(); log_cyc.delete();
  endtask

  task automatic set_lvl(input int p, input int v);
    sound_lvl[p*LW +: LW] = 8'(v);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int idx;
    int hold_c;
    wait_cycles(3);
    check("reset_evt_valid", 32'(evt_valid), 0);
    check("reset_evt_pad", 32'(evt_pad), 0);
    check("reset_evt_velocity", 32'(evt_velocity), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_pad_active", 32'(pad_active), 0);
    rst_n = 1'b1;
    wait_cycles(3);

    // Pad 2 pulse with level ramp: latency, pad and peak velocity.
    sound_ind[2] = 1'b1; set_lvl(2, 10); lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (evt_valid) begin lat = k; break; end
      @(negedge clk);
      if (k == 1) set_lvl(2, 40);
      if (k == 2) set_lvl(2, 200);
      if (k == 3) set_lvl(2, 90);
      if (k == 5) sound_ind[2] = 1'b0;
    end
    check("latency", 32'(lat), 32'(EXP_LAT));
    check("ramp_pad", 32'(evt_pad), 2);
    check("ramp_velocity", 32'(evt_velocity), 32'(EXP_VEL));
    @(negedge clk); sound_ind = '0; evt_ready = 1'b1;
    wait_cycles(50);

    // Held pad yields one event; a fresh edge after rearm yields another.
    clear_logs();
    sound_ind[0] = 1'b1; wait_cycles(100); sound_ind[0] = 1'b0; wait_cycles(50);
    check("held_count", 32'(log_pad.size()), 1);
    check("held_pad", 32'(qget(log_pad, 0)), 0);
    sound_ind[0] = 1'b1; wait_cycles(3); sound_ind[0] = 1'b0; wait_cycles(50);
    check("rearm_count", 32'(log_pad.size()), 2);

    // Contention: pads 4,1,3 on the same cycle drain in index order, one per cycle.
    clear_logs();
    sound_ind = 5'b11010; wait_cycles(3); sound_ind = '0; wait_cycles(50);
    check("contend_count", 32'(log_pad.size()), 3);
    check("contend_first", 32'(qget(log_pad, 0)), 1);
    check("contend_second", 32'(qget(log_pad, 1)), 3);
    check("contend_third", 32'(qget(log_pad, 2)), 4);
    check("contend_gap1", 32'(qget(log_cyc, 1) - qget(log_cyc, 0)), 1);
    check("contend_gap2", 32'(qget(log_cyc, 2) - qget(log_cyc, 1)), 1);

    // Overflow: all five pads with consumer stalled; pad 4 is dropped.
    evt_ready = 1'b0; clear_logs();
    sound_ind = '1; wait_cycles(3); sound_ind = '0; wait_cycles(30);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_valid", 32'(evt_valid), 1);
    check("ovf_head_pad", 32'(evt_pad), 0);
    evt_ready = 1'b1; wait_cycles(10);
    check("ovf_drain_count", 32'(log_pad.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_drain_pad%0d", i), 32'(qget(log_pad, i)), 32'(i));
    check("ovf_sticky", 32'(overflow), 1);
    wait_cycles(40);

    // Reset with two queued events and pad 1 mid-hit.
    evt_ready = 1'b0; clear_logs();
    sound_ind = 5'b00101; wait_cycles(3); sound_ind = '0; wait_cycles(25);
    check("pre_reset_valid", 32'(evt_valid), 1);
    sound_ind[1] = 1'b1; wait_cycles(5);
    rst_n = 1'b0; sound_ind = '0;
    #1;
    check("async_reset_valid", 32'(evt_valid), 0);
    check("async_reset_overflow", 32'(overflow), 0);
    check("async_reset_active", 32'(pad_active), 0);
    wait_cycles(2);
    rst_n = 1'b1; evt_ready = 1'b1; clear_logs();
    wait_cycles(40);
    check("post_reset_events", 32'(log_pad.size()), 0);
    check("post_reset_valid", 32'(evt_valid), 0);

    // Randomized traffic with alternating stalled and free-running consumer.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 24) == 0) sound_ind[p] = ~sound_ind[p];
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        set_lvl(idx, int'($urandom_range(0, 255)));
      end
      hold_c = (c / 200) % 2;
      evt_ready = (hold_c == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
    end
    @(negedge clk); sound_ind = '0; evt_ready = 1'b1;
    wait_cycles(60);
    check("final_drained", 32'(evt_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
